// File: rtl/karatsuba_acc_pkg.sv
// Shared constants and types for the Karatsuba multiply-accumulate slice.
// The default widths match the upstream 8x8 multiplier.
package karatsuba_pkg;

    localparam int KA_N  = 8;
    localparam int KA_G  = 8;
    localparam int KA_CW = 8;
    localparam int KA_W  = 2 * KA_N + KA_G;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } acc_state_t;

    // Accumulator width: full product plus guard bits
    function automatic int acc_width(input int n, input int g);
        return 2 * n + g;
    endfunction

endpackage

// File: rtl/karatsuba_acc_if.sv
// Product stream in, accumulated result out: both handshakes of karatsuba_acc.
// slave is the accumulator side, master is the producer/consumer side.
interface karatsuba_acc_if #(
    parameter int N  = karatsuba_pkg::KA_N,
    parameter int G  = karatsuba_pkg::KA_G,
    parameter int CW = karatsuba_pkg::KA_CW
) ();

    logic [2*N-1:0]   iProd;
    logic             iValid;
    logic             iLast;
    logic             oReady;
    logic [2*N+G-1:0] oSum;
    logic [CW-1:0]    oCount;
    logic             oOvf;
    logic             oValid;
    logic             iReady;

    modport slave (
        input  iProd, iValid, iLast, iReady,
        output oReady, oSum, oCount, oOvf, oValid
    );

    modport master (
        output iProd, iValid, iLast, iReady,
        input  oReady, oSum, oCount, oOvf, oValid
    );

endinterface

// File: rtl/karatsuba_acc_add.sv
// W-bit accumulate adder with carry-out. With KARATSUBA_ACC_SAT_EN defined the
// result clamps to all-ones on carry; otherwise it wraps modulo 2^W.
module karatsuba_acc_add #(
    parameter int W  = 24,
    parameter int PW = 16
) (
    input  logic [W-1:0]  acc,
    input  logic [PW-1:0] prod,
    output logic [W-1:0]  sum,
    output logic          carry
);

    logic [W:0] raw;

    // One extra bit catches the carry; a clamped acc stays clamped because any
    // nonzero addend carries again.
    always_comb begin
        raw   = {1'b0, acc} + (W + 1)'(prod);
        carry = raw[W];
`ifdef KARATSUBA_ACC_SAT_EN
        sum   = raw[W] ? {W{1'b1}} : raw[W-1:0];
`else
        sum   = raw[W-1:0];
`endif
    end

endmodule

// File: rtl/karatsuba_acc.sv
// Streaming accumulator behind the Karatsuba multiplier: sums a burst of 2N-bit
// products and presents sum/count/overflow on a valid/ready handshake.
module karatsuba_acc
    import karatsuba_pkg::*;
#(
    parameter int N  = KA_N,
    parameter int G  = KA_G,
    parameter int CW = KA_CW
) (
    input logic            iClk,
    input logic            iRst_n,
    karatsuba_acc_if.slave bus
);

    localparam int W = acc_width(N, G);

    acc_state_t    state_q, state_d;
    logic [W-1:0]  acc_q, sum_q, add_sum;
    logic [CW-1:0] cnt_q, count_q, cnt_inc;
    logic          ovf_q, sum_ovf_q, add_carry, cnt_full, accept;

    assign accept   = bus.iValid && (state_q == ACC);
    assign cnt_full = (cnt_q == {CW{1'b1}});
    assign cnt_inc  = cnt_full ? cnt_q : cnt_q + CW'(1);

    karatsuba_acc_add #(.W(W), .PW(2 * N)) u_add (
        .acc   (acc_q),
        .prod  (bus.iProd),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Leave ACC on the accepted last beat, leave OUT on the result handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (accept && bus.iLast) state_d = OUT;
            OUT:     if (bus.iReady)          state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state_q <= ACC;
        else         state_q <= state_d;
    end

    // A beat arriving with the counter already full saturates it and flags
    // overflow, the same as an adder carry.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            sum_ovf_q <= 1'b0;
        end else if (accept) begin
            if (bus.iLast) begin
                sum_q     <= add_sum;
                count_q   <= cnt_inc;
                sum_ovf_q <= ovf_q | add_carry | cnt_full;
                acc_q     <= '0;
                cnt_q     <= '0;
                ovf_q     <= 1'b0;
            end else begin
                acc_q <= add_sum;
                cnt_q <= cnt_inc;
                ovf_q <= ovf_q | add_carry | cnt_full;
            end
        end
    end

    assign bus.oReady = (state_q == ACC);
    assign bus.oValid = (state_q == OUT);
    assign bus.oSum   = sum_q;
    assign bus.oCount = count_q;
    assign bus.oOvf   = sum_ovf_q;

endmodule

// File: tb/tb_karatsuba_acc.sv
// Self-checking bench for karatsuba_acc: a default-width instance and a G=0/CW=2
// instance for the overflow corners, checked against a burst-level sum model.
module tb_karatsuba_acc;

    localparam int NA = 8, GA = 8, CWA = 8, WA = 2 * NA + GA;
    localparam int NB = 8, GB = 0, CWB = 2, WB = 2 * NB + GB;
`ifdef KARATSUBA_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    longint stim_prod[$];
    bit     stim_last[$];
    longint exp_sum[$];
    longint exp_cnt[$];
    bit     exp_ovf[$];
    longint res_sum[$];
    longint res_cnt[$];
    bit     res_ovf[$];
    int     ready_low;
    bit     stream_timeout;

    always #5 clk = ~clk;

    karatsuba_acc_if #(.N(NA), .G(GA), .CW(CWA)) bus_a ();
    karatsuba_acc_if #(.N(NB), .G(GB), .CW(CWB)) bus_b ();

    karatsuba_acc #(.N(NA), .G(GA), .CW(CWA)) dut_a (.iClk(clk), .iRst_n(rst_n), .bus(bus_a));
    karatsuba_acc #(.N(NB), .G(GB), .CW(CWB)) dut_b (.iClk(clk), .iRst_n(rst_n), .bus(bus_b));

    // Whole-burst reference: true sum, then wrap or clamp; count saturates.
    function automatic void model(input longint prods[$], input int w, input int cw,
                                  output longint sum, output longint cnt, output bit ovf);
        longint total = 0;
        longint lim   = longint'(1) << w;
        longint cmax  = (longint'(1) << cw) - 1;
        foreach (prods[i]) total += prods[i];
        ovf = (total >= lim) || (longint'(prods.size()) > cmax);
        cnt = (longint'(prods.size()) > cmax) ? cmax : longint'(prods.size());
        if (total < lim) sum = total;
        else if (SAT)    sum = lim - 1;
        else             sum = total % lim;
    endfunction

    task automatic drive_burst_a(input longint prods[$]);
        foreach (prods[i]) begin
            bus_a.iProd  = 16'(prods[i]);
            bus_a.iValid = 1'b1;
            bus_a.iLast  = (i == prods.size() - 1);
            @(posedge clk); #1;
        end
        bus_a.iValid = 1'b0;
        bus_a.iLast  = 1'b0;
    endtask

    task automatic drive_burst_b(input longint prods[$]);
        foreach (prods[i]) begin
            bus_b.iProd  = 16'(prods[i]);
            bus_b.iValid = 1'b1;
            bus_b.iLast  = (i == prods.size() - 1);
            @(posedge clk); #1;
        end
        bus_b.iValid = 1'b0;
        bus_b.iLast  = 1'b0;
    endtask

    task automatic handshake_a();
        bus_a.iReady = 1'b1;
        @(posedge clk); #1;
        bus_a.iReady = 1'b0;
    endtask

    task automatic handshake_b();
        bus_b.iReady = 1'b1;
        @(posedge clk); #1;
        bus_b.iReady = 1'b0;
    endtask

    // Plays stim_* into instance A with optional valid gaps and random iReady,
    // collecting every result at its handshake into res_*.
    task automatic run_stream_a(input bit rand_ready, input bit rand_gap);
        int idx  = 0;
        int nres = 0;
        int cyc  = 0;
        bit take;
        res_sum = {}; res_cnt = {}; res_ovf = {};
        ready_low = 0;
        foreach (stim_last[i]) if (stim_last[i]) nres++;
        while ((idx < stim_prod.size() || res_sum.size() < nres) && cyc < 4000) begin
            if (idx < stim_prod.size() && (!rand_gap || $urandom_range(3) != 0)) begin
                bus_a.iValid = 1'b1;
                bus_a.iProd  = 16'(stim_prod[idx]);
                bus_a.iLast  = stim_last[idx];
            end else begin
                bus_a.iValid = 1'b0;
                bus_a.iProd  = 16'($urandom);
                bus_a.iLast  = ($urandom_range(1) == 1);
            end
            bus_a.iReady = rand_ready ? ($urandom_range(1) == 1) : 1'b1;
            take = bus_a.iValid && bus_a.oReady;
            if (bus_a.oValid && bus_a.iReady) begin
                res_sum.push_back(longint'(bus_a.oSum));
                res_cnt.push_back(longint'(bus_a.oCount));
                res_ovf.push_back(bus_a.oOvf);
            end
            @(posedge clk); #1;
            cyc++;
            if (take) idx++;
            if (!bus_a.oReady) ready_low++;
        end
        stream_timeout = (idx < stim_prod.size() || res_sum.size() < nres);
        bus_a.iValid = 1'b0;
        bus_a.iLast  = 1'b0;
        bus_a.iReady = 1'b0;
    endtask

    task automatic add_burst_a(input int len);
        longint q[$];
        longint es, ec;
        bit     eo;
        for (int k = 0; k < len; k++) begin
            q.push_back(longint'($urandom_range(255)) * longint'($urandom_range(255)));
            stim_prod.push_back(q[k]);
            stim_last.push_back(k == len - 1);
        end
        model(q, WA, CWA, es, ec, eo);
        exp_sum.push_back(es);
        exp_cnt.push_back(ec);
        exp_ovf.push_back(eo);
    endtask

    task automatic test_reset();
        longint q[$];
        vectors++;
        if ({bus_a.oValid, bus_a.oOvf, bus_a.oReady, bus_a.oCount, bus_a.oSum} !== {1'b0, 1'b0, 1'b1, 8'd0, 24'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %h expected %h",
                     {bus_a.oValid, bus_a.oOvf, bus_a.oReady, bus_a.oCount, bus_a.oSum}, {1'b0, 1'b0, 1'b1, 8'd0, 24'd0});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            bus_a.iValid = 1'b1;
            bus_a.iLast  = 1'b0;
            bus_a.iProd  = 16'(100 + k);
            @(posedge clk); #1;
        end
        bus_a.iValid = 1'b0;
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({bus_a.oValid, bus_a.oOvf, bus_a.oReady, bus_a.oCount, bus_a.oSum} !== {1'b0, 1'b0, 1'b1, 8'd0, 24'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_burst: got %h expected %h",
                     {bus_a.oValid, bus_a.oOvf, bus_a.oReady, bus_a.oCount, bus_a.oSum}, {1'b0, 1'b0, 1'b1, 8'd0, 24'd0});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        q = {64'd5};
        drive_burst_a(q);
        vectors++;
        if ({bus_a.oValid, bus_a.oOvf, bus_a.oCount, bus_a.oSum} !== {1'b1, 1'b0, 8'd1, 24'd5}) begin
            miscompares++;
            $display("[TB] FAIL reset_next_burst: got %h expected %h",
                     {bus_a.oValid, bus_a.oOvf, bus_a.oCount, bus_a.oSum}, {1'b1, 1'b0, 8'd1, 24'd5});
        end
        handshake_a();
    endtask

    task automatic test_known_burst();
        bus_a.iValid = 1'b1; bus_a.iLast = 1'b0; bus_a.iProd = 16'hFE01;
        @(posedge clk); #1;
        bus_a.iProd = 16'h0100;
        @(posedge clk); #1;
        vectors++;
        if ({bus_a.oValid, bus_a.oReady} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL known_mid_burst: got %b expected %b", {bus_a.oValid, bus_a.oReady}, 2'b01);
        end
        bus_a.iProd = 16'h0001; bus_a.iLast = 1'b1;
        @(posedge clk); #1;
        bus_a.iValid = 1'b0; bus_a.iLast = 1'b0;
        vectors++;
        if ({bus_a.oValid, bus_a.oReady, bus_a.oOvf, bus_a.oCount, bus_a.oSum} !== {1'b1, 1'b0, 1'b0, 8'd3, 24'h00FF02}) begin
            miscompares++;
            $display("[TB] FAIL known_result: got %h expected %h",
                     {bus_a.oValid, bus_a.oReady, bus_a.oOvf, bus_a.oCount, bus_a.oSum}, {1'b1, 1'b0, 1'b0, 8'd3, 24'h00FF02});
        end
        handshake_a();
        vectors++;
        if ({bus_a.oValid, bus_a.oReady, bus_a.oSum} !== {1'b0, 1'b1, 24'h00FF02}) begin
            miscompares++;
            $display("[TB] FAIL known_after_handshake: got %h expected %h",
                     {bus_a.oValid, bus_a.oReady, bus_a.oSum}, {1'b0, 1'b1, 24'h00FF02});
        end
    endtask

    task automatic test_back_to_back();
        stim_prod = {}; stim_last = {}; exp_sum = {}; exp_cnt = {}; exp_ovf = {};
        add_burst_a(3);
        add_burst_a(2);
        run_stream_a(1'b0, 1'b0);
        vectors++;
        if (stream_timeout || ready_low != 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_ready_low: got %0d cycles (timeout %0d) expected 2", ready_low, stream_timeout);
        end
        for (int i = 0; i < exp_sum.size(); i++) begin
            vectors++;
            if (i >= res_sum.size()) begin
                miscompares++;
                $display("[TB] FAIL b2b_burst%0d: got no result expected sum %h", i, exp_sum[i]);
            end else if ({res_ovf[i], 8'(res_cnt[i]), 24'(res_sum[i])} !== {exp_ovf[i], 8'(exp_cnt[i]), 24'(exp_sum[i])}) begin
                miscompares++;
                $display("[TB] FAIL b2b_burst%0d: got %h expected %h", i,
                         {res_ovf[i], 8'(res_cnt[i]), 24'(res_sum[i])}, {exp_ovf[i], 8'(exp_cnt[i]), 24'(exp_sum[i])});
            end
        end
    endtask

    task automatic test_backpressure();
        longint q[$];
        q = {64'h1234, 64'h0042};
        drive_burst_a(q);
        for (int c = 0; c < 5; c++) begin
            bus_a.iReady = 1'b0;
            bus_a.iValid = 1'b1;
            bus_a.iLast  = 1'b1;
            bus_a.iProd  = 16'($urandom);
            vectors++;
            if ({bus_a.oValid, bus_a.oReady, bus_a.oCount, bus_a.oSum} !== {1'b1, 1'b0, 8'd2, 24'h001276}) begin
                miscompares++;
                $display("[TB] FAIL backpressure_hold%0d: got %h expected %h", c,
                         {bus_a.oValid, bus_a.oReady, bus_a.oCount, bus_a.oSum}, {1'b1, 1'b0, 8'd2, 24'h001276});
            end
            @(posedge clk); #1;
        end
        handshake_a();
        bus_a.iValid = 1'b0;
        bus_a.iLast  = 1'b0;
        vectors++;
        if ({bus_a.oValid, bus_a.oReady} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL backpressure_release: got %b expected %b", {bus_a.oValid, bus_a.oReady}, 2'b01);
        end
        q = {64'd7};
        drive_burst_a(q);
        vectors++;
        if ({bus_a.oValid, bus_a.oOvf, bus_a.oCount, bus_a.oSum} !== {1'b1, 1'b0, 8'd1, 24'd7}) begin
            miscompares++;
            $display("[TB] FAIL backpressure_next: got %h expected %h",
                     {bus_a.oValid, bus_a.oOvf, bus_a.oCount, bus_a.oSum}, {1'b1, 1'b0, 8'd1, 24'd7});
        end
        handshake_a();
    endtask

    task automatic test_random_stream();
        stim_prod = {}; stim_last = {}; exp_sum = {}; exp_cnt = {}; exp_ovf = {};
        for (int b = 0; b < 8; b++) add_burst_a(int'($urandom_range(6, 1)));
        run_stream_a(1'b1, 1'b1);
        vectors++;
        if (stream_timeout) begin
            miscompares++;
            $display("[TB] FAIL random_stream_timeout: got %0d results expected %0d", res_sum.size(), exp_sum.size());
        end
        for (int i = 0; i < exp_sum.size(); i++) begin
            vectors++;
            if (i >= res_sum.size()) begin
                miscompares++;
                $display("[TB] FAIL random_burst%0d: got no result expected sum %h", i, exp_sum[i]);
            end else if ({res_ovf[i], 8'(res_cnt[i]), 24'(res_sum[i])} !== {exp_ovf[i], 8'(exp_cnt[i]), 24'(exp_sum[i])}) begin
                miscompares++;
                $display("[TB] FAIL random_burst%0d: got %h expected %h", i,
                         {res_ovf[i], 8'(res_cnt[i]), 24'(res_sum[i])}, {exp_ovf[i], 8'(exp_cnt[i]), 24'(exp_sum[i])});
            end
        end
    endtask

    task automatic test_overflow_wrap();
        longint q[$];
        logic [15:0] want = SAT ? 16'hFFFF : 16'h0001;
        q = {64'hFFFF, 64'h0002};
        drive_burst_b(q);
        vectors++;
        if ({bus_b.oValid, bus_b.oOvf, bus_b.oCount, bus_b.oSum} !== {1'b1, 1'b1, 2'd2, want}) begin
            miscompares++;
            $display("[TB] FAIL overflow_g0: got %h expected %h",
                     {bus_b.oValid, bus_b.oOvf, bus_b.oCount, bus_b.oSum}, {1'b1, 1'b1, 2'd2, want});
        end
        handshake_b();
    endtask

    task automatic test_count_sat();
        longint q[$];
        q = {64'd1, 64'd1, 64'd1, 64'd1, 64'd1};
        drive_burst_b(q);
        vectors++;
        if ({bus_b.oValid, bus_b.oOvf, bus_b.oCount, bus_b.oSum} !== {1'b1, 1'b1, 2'd3, 16'd5}) begin
            miscompares++;
            $display("[TB] FAIL count_sat: got %h expected %h",
                     {bus_b.oValid, bus_b.oOvf, bus_b.oCount, bus_b.oSum}, {1'b1, 1'b1, 2'd3, 16'd5});
        end
        handshake_b();
    endtask

    task automatic test_random_b();
        longint q[$];
        longint es, ec;
        bit     eo;
        int     len;
        for (int b = 0; b < 10; b++) begin
            q = {};
            len = int'($urandom_range(6, 1));
            for (int k = 0; k < len; k++)
                q.push_back(longint'($urandom_range(255)) * longint'($urandom_range(255)));
            drive_burst_b(q);
            model(q, WB, CWB, es, ec, eo);
            vectors++;
            if ({bus_b.oValid, bus_b.oOvf, bus_b.oCount, bus_b.oSum} !== {1'b1, eo, 2'(ec), 16'(es)}) begin
                miscompares++;
                $display("[TB] FAIL random_narrow%0d: got %h expected %h", b,
                         {bus_b.oValid, bus_b.oOvf, bus_b.oCount, bus_b.oSum}, {1'b1, eo, 2'(ec), 16'(es)});
            end
            handshake_b();
        end
    endtask

    initial begin
        bus_a.iProd = '0; bus_a.iValid = 1'b0; bus_a.iLast = 1'b0; bus_a.iReady = 1'b0;
        bus_b.iProd = '0; bus_b.iValid = 1'b0; bus_b.iLast = 1'b0; bus_b.iReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_known_burst();
        test_back_to_back();
        test_backpressure();
        test_random_stream();
        test_overflow_wrap();
        test_count_sat();
        test_random_b();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
